// File: rtl/bytestream_tx_arbiter_pkg.sv
// Shared sizing and FSM encoding for the bytestream transmit arbiter.
package bytestream_tx_arbiter_pkg;
    localparam int NUM_REQ = 4;
    localparam int GRANT_W = $clog2(NUM_REQ);
    localparam int WDOG_W  = 10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/bytestream_tx_arbiter_rr_pick.sv
// Round-robin pick: first set request searching upward (with wrap) from last_grant+1.
module rr_pick
    import bytestream_tx_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last_grant,
    output logic [GRANT_W-1:0] pick_idx,
    output logic               found
);
    logic [GRANT_W-1:0] cand;

    // Walk from farthest to nearest so the nearest candidate is assigned last and wins.
    always_comb begin
        pick_idx = last_grant;
        found    = 1'b0;
        cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bytestream_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding a UART bytestream transmit channel.
//   state     | meaning
//   ST_IDLE   | no owner; pick next requester, register grant
//   ST_LOCKED | granted requester streams bytes until last byte or watchdog release
module bytestream_tx_arbiter
    import bytestream_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_consume,
    output logic [7:0]           bs_data_in,
    output logic                 bs_data_in_valid,
    input  logic                 bs_data_in_consume,
    output logic [GRANT_W-1:0]   grant_idx,
    output logic                 timeout_pulse
);
    state_t             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_grant_q, last_grant_d;
    logic [GRANT_W-1:0] pick_idx;
    logic               pick_found;
    logic [WDOG_W-1:0]  wdog_q, wdog_d, wdog_inc;
    logic               timeout_q, timeout_d;
    logic               locked;
    logic               gnt_valid;
    logic               gnt_last;

    rr_pick u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .pick_idx   (pick_idx),
        .found      (pick_found)
    );

    // Reset gates the datapath immediately so a packet in flight sees no more strobes.
    assign locked    = (state_q == ST_LOCKED) && !reset;
    assign gnt_valid = req_valid[grant_q];
    assign gnt_last  = req_last[grant_q];
    assign wdog_inc  = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wdog_d       = wdog_q;
        timeout_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    wdog_d  = '0;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (bs_data_in_consume && gnt_last) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    wdog_d       = '0;
                end else if (gnt_valid) begin
                    wdog_d = '0;
                end else if (int'(wdog_inc) >= TIMEOUT) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                    wdog_d       = '0;
                    timeout_d    = 1'b1;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            wdog_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wdog_q       <= wdog_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bs_data_in       = locked ? req_data[{grant_q, 3'b000} +: 8] : 8'h00;
    assign bs_data_in_valid = locked && gnt_valid;
    assign req_consume      = locked ? (NUM_REQ'(bs_data_in_consume) << grant_q) : '0;
    assign grant_idx        = grant_q;
    assign timeout_pulse    = timeout_q;
endmodule
